tron_round_ctrl: RTL

Match/round sequencer for the two-player Tron game. Takes crash events from the game datapath, decides each round's outcome, and tracks both players' scores as 2-digit BCD for the hex displays. Also sequences the pre-round countdown, the round-end hold and match-over. It replaces direct key/switch driving of the score counters and sits between the collision logic and the score display path.

---
 rtl/tron_pkg.sv | 33 +++
 rtl/bcd_score_counter.sv | 33 +++
 rtl/tron_round_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tron_pkg.sv
// Shared types and constants for the Tron match/round sequencer.
package tron_pkg;

  // Sequencer states; the encoding is visible on the state_dbg output.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_PLAY       = 3'd2,
    ST_ROUND_END  = 3'd3,
    ST_MATCH_OVER = 3'd4
  } tron_state_e;

  // round_result codes
  localparam logic [1:0] RR_NONE = 2'b00;
  localparam logic [1:0] RR_P1   = 2'b01;
  localparam logic [1:0] RR_P2   = 2'b10;
  localparam logic [1:0] RR_DRAW = 2'b11;

  // winner codes
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Convert a decimal value 0..99 into {tens, ones} BCD.
  function automatic logic [7:0] to_bcd(input int v);
    int t;
    int o;
    t = v / 10;
    o = v % 10;
    return {t[3:0], o[3:0]};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter that saturates at 99.
module bcd_score_counter (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] out
);

  logic [3:0] tens;
  logic [3:0] ones;

  assign tens = out[7:4];
  assign ones = out[3:0];

  // Clear wins over increment; at 99 the score holds; ones wrap 9->0 with carry.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      out <= 8'h00;
    end else if (clr) begin
      out <= 8'h00;
    end else if (inc) begin
      if (out == 8'h99) begin
        out <= 8'h99;
      end else if (ones >= 4'd9) begin
        out <= {tens + 4'd1, 4'd0};
      end else begin
        out <= {tens, ones + 4'd1};
      end
    end
  end

endmodule

// File: rtl/tron_round_ctrl.sv
// Match/round sequencer: countdown, play, round-end hold and match-over,
// with crash decoding and BCD score keeping for both players.
//
// Handshake: tick and start are single-cycle strobes with no back-pressure;
// crash_p1/crash_p2 are levels sampled on every clk. Outputs are registered
// and change on the rising edge after the cause.
module tron_round_ctrl
  import tron_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int COUNT_TICKS = 3,
  parameter int HOLD_TICKS  = 2
) (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       tick,
  input  logic       start,
  input  logic       crash_p1,
  input  logic       crash_p2,
  output logic       game_run,
  output logic [3:0] countdown,
  output logic       p1_point,
  output logic       p2_point,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic [1:0] round_result,
  output logic       match_over,
  output logic [1:0] winner,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] WIN_BCD    = to_bcd(WIN_SCORE);
  localparam logic [3:0] COUNT_LOAD = 4'(COUNT_TICKS);
  localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_TICKS);

  tron_state_e state_q, state_d;
  logic [3:0]  countdown_d;
  logic [3:0]  hold_q, hold_d;
  logic [1:0]  rr_d;
  logic [1:0]  winner_d;
  logic        p1_d, p2_d;
  logic        run_d, over_d;
  logic        score_clr, inc1, inc2;

  assign state_dbg = state_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_q      <= ST_IDLE;
      countdown    <= 4'd0;
      hold_q       <= 4'd0;
      round_result <= RR_NONE;
      winner       <= WIN_NONE;
      p1_point     <= 1'b0;
      p2_point     <= 1'b0;
      game_run     <= 1'b0;
      match_over   <= 1'b0;
    end else begin
      state_q      <= state_d;
      countdown    <= countdown_d;
      hold_q       <= hold_d;
      round_result <= rr_d;
      winner       <= winner_d;
      p1_point     <= p1_d;
      p2_point     <= p2_d;
      game_run     <= run_d;
      match_over   <= over_d;
    end
  end

  // Next-state, counters, crash decode and score control.
  always_comb begin
    state_d     = state_q;
    countdown_d = countdown;
    hold_d      = hold_q;
    rr_d        = round_result;
    winner_d    = winner;
    p1_d        = 1'b0;
    p2_d        = 1'b0;
    score_clr   = 1'b0;
    inc1        = 1'b0;
    inc2        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = COUNT_LOAD;
          score_clr   = 1'b1;
          rr_d        = RR_NONE;
        end
      end
      ST_COUNTDOWN: begin
        if (tick) begin
          if (countdown <= 4'd1) begin
            state_d     = ST_PLAY;
            countdown_d = 4'd0;
          end else begin
            countdown_d = countdown - 4'd1;
          end
        end
      end
      ST_PLAY: begin
        if (crash_p1 || crash_p2) begin
          state_d = ST_ROUND_END;
          hold_d  = HOLD_LOAD;
          if (crash_p1 && crash_p2) begin
            rr_d = RR_DRAW;
          end else if (crash_p1) begin
            rr_d = RR_P2;
            p2_d = 1'b1;
            inc2 = 1'b1;
          end else begin
            rr_d = RR_P1;
            p1_d = 1'b1;
            inc1 = 1'b1;
          end
        end
      end
      ST_ROUND_END: begin
        // Scores are already updated on entry and cannot change here.
        if (tick) begin
          if (hold_q <= 4'd1) begin
            hold_d = 4'd0;
            if (score1 == WIN_BCD || score2 == WIN_BCD) begin
              state_d  = ST_MATCH_OVER;
              winner_d = (score1 == WIN_BCD) ? WIN_P1 : WIN_P2;
            end else begin
              state_d     = ST_COUNTDOWN;
              countdown_d = COUNT_LOAD;
            end
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end
      ST_MATCH_OVER: begin
        if (start) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = COUNT_LOAD;
          score_clr   = 1'b1;
          winner_d    = WIN_NONE;
          rr_d        = RR_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    run_d  = (state_d == ST_PLAY);
    over_d = (state_d == ST_MATCH_OVER);
  end

  bcd_score_counter u_score1 (
    .clk     (clk),
    .clear_b (clear_b),
    .clr     (score_clr),
    .inc     (inc1),
    .out     (score1)
  );

  bcd_score_counter u_score2 (
    .clk     (clk),
    .clear_b (clear_b),
    .clr     (score_clr),
    .inc     (inc2),
    .out     (score2)
  );

endmodule
